// File: rtl/nonce_search.sv
// Bus-master sequencer for the SHA-256 hash slave: walks a nonce range, hashing
// header+nonce, and stops on the first D7 strictly below target or at range end.
module nonce_search (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] header,
   input  logic [31:0] nonce_start,
   input  logic [31:0] nonce_end,
   input  logic [31:0] target,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        found,
   output logic [31:0] nonce_out,
   output logic [31:0] digest_hi,
   output logic [31:0] hash_count,
   output logic [3:0]  master_address,
   output logic        master_write,
   output logic        master_read,
   output logic [31:0] master_writedata,
   input  logic [31:0] master_readdata,
   input  logic        master_waitrequest
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR_W0 = 3'd1,
      WR_W1 = 3'd2,
      WR_GO = 3'd3,
      RD_D7 = 3'd4,
      CHECK = 3'd5,
      DONE  = 3'd6
   } state_t;

   localparam logic [3:0] ADDR_GO   = 4'd0;
   localparam logic [3:0] ADDR_W0   = 4'd1;
   localparam logic [3:0] ADDR_W1   = 4'd2;
   localparam logic [3:0] ADDR_D7   = 4'd3;

   state_t      state_reg, state_next;
   logic [31:0] header_reg;
   logic [31:0] nonce_end_reg;
   logic [31:0] target_reg;
   logic [31:0] cur_reg;
   logic [31:0] d7_reg;
   logic [31:0] hash_count_reg;
   logic [31:0] nonce_out_reg;
   logic [31:0] digest_hi_reg;
   logic        found_reg;
   // Set once the word0 write has been presented and stalled; abort must then
   // wait for the transfer to finish rather than drop the strobe mid-stall.
   logic        w0_pending_reg;

   logic        hit;
   logic        last_nonce;

   assign hit        = (d7_reg < target_reg);
   assign last_nonce = (cur_reg == nonce_end_reg);

   always_comb begin
      state_next       = state_reg;
      busy             = 1'b0;
      done             = 1'b0;
      master_address   = 4'd0;
      master_write     = 1'b0;
      master_read      = 1'b0;
      master_writedata = 32'd0;
      case (state_reg)
         IDLE: begin
            if (start)
               state_next = WR_W0;
         end
         WR_W0: begin
            busy = 1'b1;
            if (abort && !w0_pending_reg) begin
               state_next = DONE;
            end else begin
               master_write     = 1'b1;
               master_address   = ADDR_W0;
               master_writedata = cur_reg;
               if (!master_waitrequest)
                  state_next = WR_W1;
            end
         end
         WR_W1: begin
            busy             = 1'b1;
            master_write     = 1'b1;
            master_address   = ADDR_W1;
            master_writedata = header_reg;
            if (!master_waitrequest)
               state_next = WR_GO;
         end
         WR_GO: begin
            busy             = 1'b1;
            master_write     = 1'b1;
            master_address   = ADDR_GO;
            master_writedata = 32'd1;
            if (!master_waitrequest)
               state_next = RD_D7;
         end
         RD_D7: begin
            busy           = 1'b1;
            master_read    = 1'b1;
            master_address = ADDR_D7;
            if (!master_waitrequest)
               state_next = CHECK;
         end
         CHECK: begin
            busy = 1'b1;
            if (hit || last_nonce || abort)
               state_next = DONE;
            else
               state_next = WR_W0;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         header_reg     <= 32'd0;
         nonce_end_reg  <= 32'd0;
         target_reg     <= 32'd0;
         cur_reg        <= 32'd0;
         d7_reg         <= 32'd0;
         hash_count_reg <= 32'd0;
         nonce_out_reg  <= 32'd0;
         digest_hi_reg  <= 32'd0;
         found_reg      <= 1'b0;
         w0_pending_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         w0_pending_reg <= (state_reg == WR_W0) && master_write && master_waitrequest;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  header_reg     <= header;
                  nonce_end_reg  <= nonce_end;
                  target_reg     <= target;
                  cur_reg        <= nonce_start;
                  hash_count_reg <= 32'd0;
                  found_reg      <= 1'b0;
               end
            end
            RD_D7: begin
               if (!master_waitrequest) begin
                  d7_reg         <= master_readdata;
                  hash_count_reg <= hash_count_reg + 32'd1;
               end
            end
            CHECK: begin
               nonce_out_reg <= cur_reg;
               digest_hi_reg <= d7_reg;
               if (hit)
                  found_reg <= 1'b1;
               else if (last_nonce || abort)
                  found_reg <= 1'b0;
               else
                  cur_reg <= cur_reg + 32'd1;
            end
            default: ;
         endcase
      end
   end

   assign found      = found_reg;
   assign nonce_out  = nonce_out_reg;
   assign digest_hi  = digest_hi_reg;
   assign hash_count = hash_count_reg;

endmodule
